// File: rtl/vec_mul4_issuer.sv
// Job-based producer for the 4-lane product interface: accepts paired 4 x uint8 operand
// words and issues four 8x8 unsigned products per accepted beat, marking the job's last chunk.
module vec_mul4_issuer #(
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             abort,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [31:0]      op_a,
   input  logic [31:0]      op_b,
   output logic             out_valid,
   output logic             out_last,
   output logic [15:0]      p0,
   output logic [15:0]      p1,
   output logic [15:0]      p2,
   output logic [15:0]      p3,
   output logic             busy,
   output logic             done
);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [LEN_W-1:0] r_remaining;
   logic [LEN_W-1:0] w_remaining_nxt;
   logic             w_beat;
   logic             w_last_nxt;
   logic             w_done_nxt;
   logic [15:0]      w_prod0, w_prod1, w_prod2, w_prod3;

   assign w_prod0 = {8'd0, op_a[7:0]}   * {8'd0, op_b[7:0]};
   assign w_prod1 = {8'd0, op_a[15:8]}  * {8'd0, op_b[15:8]};
   assign w_prod2 = {8'd0, op_a[23:16]} * {8'd0, op_b[23:16]};
   assign w_prod3 = {8'd0, op_a[31:24]} * {8'd0, op_b[31:24]};

   // abort gates op_ready so a beat offered in the abort cycle is never taken
   always_comb begin
      w_state_nxt     = r_state;
      w_remaining_nxt = r_remaining;
      op_ready        = 1'b0;
      busy            = 1'b0;
      w_beat          = 1'b0;
      w_last_nxt      = 1'b0;
      w_done_nxt      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start && !abort) begin
               if (len != '0) begin
                  w_state_nxt     = S_RUN;
                  w_remaining_nxt = len;
               end else begin
                  w_done_nxt = 1'b1;
               end
            end
         end
         S_RUN: begin
            busy     = 1'b1;
            op_ready = !abort;
            w_beat   = op_valid && !abort;
            if (abort) begin
               w_state_nxt     = S_IDLE;
               w_remaining_nxt = '0;
            end else if (w_beat) begin
               w_remaining_nxt = r_remaining - LEN_W'(1);
               if (r_remaining == LEN_W'(1)) begin
                  w_last_nxt  = 1'b1;
                  w_done_nxt  = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_remaining <= '0;
         out_valid   <= 1'b0;
         out_last    <= 1'b0;
         done        <= 1'b0;
         p0          <= '0;
         p1          <= '0;
         p2          <= '0;
         p3          <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_remaining <= w_remaining_nxt;
         out_valid   <= w_beat;
         out_last    <= w_last_nxt;
         done        <= w_done_nxt;
         if (w_beat) begin
            p0 <= w_prod0;
            p1 <= w_prod1;
            p2 <= w_prod2;
            p3 <= w_prod3;
         end
      end
   end

endmodule

// File: tb/tb_vec_mul4_issuer.sv
// Self-checking bench for vec_mul4_issuer: directed job scenarios plus random traffic
// compared against a job-level reference model.
module tb_vec_mul4_issuer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  len;
   logic        abort;
   logic        op_valid;
   logic        op_ready;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        out_valid;
   logic        out_last;
   logic [15:0] p0, p1, p2, p3;
   logic        busy;
   logic        done;

   int total = 0;
   int bad   = 0;

   // reference model: job in flight, chunks still owed, expected registered outputs
   bit          m_job;
   int          m_rem;
   bit          m_valid, m_last, m_done;
   logic [15:0] m_p[4];

   vec_mul4_issuer #(.LEN_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
      .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
      .out_valid(out_valid), .out_last(out_last),
      .p0(p0), .p1(p1), .p2(p2), .p3(p3), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_job = 0; m_rem = 0; m_valid = 0; m_last = 0; m_done = 0;
      for (int i = 0; i < 4; i++) m_p[i] = '0;
   endtask

   task automatic check_outs();
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      chk("out_last",  {31'd0, out_last},  {31'd0, m_last});
      chk("done",      {31'd0, done},      {31'd0, m_done});
      chk("p0", {16'd0, p0}, {16'd0, m_p[0]});
      chk("p1", {16'd0, p1}, {16'd0, m_p[1]});
      chk("p2", {16'd0, p2}, {16'd0, m_p[2]});
      chk("p3", {16'd0, p3}, {16'd0, m_p[3]});
   endtask

   // one clock: drive inputs, check combinational outputs, advance model, check registers
   task automatic step(input bit v, input logic [31:0] a, input logic [31:0] b,
                       input bit s, input logic [7:0] l, input bit ab);
      @(negedge clk);
      op_valid = v; op_a = a; op_b = b; start = s; len = l; abort = ab;
      #1;
      chk("op_ready", {31'd0, op_ready}, {31'd0, m_job && !ab});
      chk("busy",     {31'd0, busy},     {31'd0, m_job});
      if (m_job) begin
         if (ab) begin
            m_job = 0; m_rem = 0; m_valid = 0; m_last = 0; m_done = 0;
         end else if (v) begin
            for (int i = 0; i < 4; i++)
               m_p[i] = {8'd0, a[8*i +: 8]} * {8'd0, b[8*i +: 8]};
            m_valid = 1;
            m_rem   = m_rem - 1;
            m_last  = (m_rem == 0);
            m_done  = m_last;
            if (m_last) m_job = 0;
         end else begin
            m_valid = 0; m_last = 0; m_done = 0;
         end
      end else begin
         m_valid = 0; m_last = 0;
         m_done  = s && !ab && (l == 0);
         if (s && !ab && l != 0) begin
            m_job = 1; m_rem = int'(l);
         end
      end
      @(posedge clk);
      #1;
      check_outs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 32'h0, 32'h0, 0, 8'd0, 0);
   endtask

   initial begin
      logic [17:0] sum;
      int          nvalid;
      bit          pat[7];

      rst = 1'b1; start = 0; len = 0; abort = 0; op_valid = 0; op_a = 0; op_b = 0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_busy",     {31'd0, busy},      32'd0);
      chk("rst_op_ready", {31'd0, op_ready},  32'd0);
      check_outs();

      // T2 single chunk
      step(0, 32'h0, 32'h0, 1, 8'd1, 0);
      step(1, 32'h04030201, 32'h08070605, 0, 8'd0, 0);
      chk("t2_p0", {16'd0, p0}, 32'd5);
      chk("t2_p1", {16'd0, p1}, 32'd12);
      chk("t2_p2", {16'd0, p2}, 32'd21);
      chk("t2_p3", {16'd0, p3}, 32'd32);
      chk("t2_last", {31'd0, out_last & done & out_valid}, 32'd1);
      chk("t2_busy", {31'd0, busy}, 32'd0);
      idle(1);

      // T3 max values, three continuous beats
      step(0, 32'h0, 32'h0, 1, 8'd3, 0);
      for (int i = 0; i < 3; i++) begin
         step(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 8'd0, 0);
         chk("t3_pmax", {16'd0, p2}, 32'h0000FE01);
         sum = 18'(p0) + 18'(p1) + 18'(p2) + 18'(p3);
         chk("t3_sum", {14'd0, sum}, 32'h0003F804);
      end
      idle(1);

      // T4 bubbles
      pat = '{1, 0, 0, 1, 1, 0, 1};
      step(0, 32'h0, 32'h0, 1, 8'd4, 0);
      for (int i = 0; i < 7; i++)
         step(pat[i], $urandom, $urandom, 0, 8'd0, 0);
      idle(1);

      // T5 zero-length job
      nvalid = 0;
      step(0, 32'h0, 32'h0, 1, 8'd0, 0);
      chk("t5_done", {31'd0, done}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         step(1, $urandom, $urandom, 0, 8'd0, 0);
         nvalid += int'(out_valid);
      end
      chk("t5_novalid", nvalid, 32'd0);

      // T6 abort after 2 of 5 beats, then a fresh job
      step(0, 32'h0, 32'h0, 1, 8'd5, 0);
      step(1, $urandom, $urandom, 0, 8'd0, 0);
      step(1, $urandom, $urandom, 0, 8'd0, 0);
      step(1, $urandom, $urandom, 0, 8'd0, 1);
      chk("t6_abort_done", {31'd0, done}, 32'd0);
      step(1, $urandom, $urandom, 0, 8'd0, 0);
      step(0, 32'h0, 32'h0, 1, 8'd2, 0);
      step(1, $urandom, $urandom, 1, 8'd9, 0);
      step(1, $urandom, $urandom, 0, 8'd0, 0);
      chk("t6_done", {31'd0, done}, 32'd1);
      idle(1);

      // abort together with start in IDLE: abort wins
      step(0, 32'h0, 32'h0, 1, 8'd3, 1);
      idle(1);

      // random traffic
      for (int c = 0; c < 1500; c++)
         step(($urandom_range(0, 3) != 0), $urandom, $urandom,
              ($urandom_range(0, 3) == 0), 8'($urandom_range(0, 5)),
              ($urandom_range(0, 19) == 0));

      // T1 reset mid-job with op_valid high
      idle(1);
      step(0, 32'h0, 32'h0, 1, 8'd4, 0);
      step(1, 32'h01010101, 32'h02020202, 0, 8'd0, 0);
      @(negedge clk);
      op_valid = 1; op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF;
      rst = 1'b1;
      #1;
      model_reset();
      chk("t1_busy",     {31'd0, busy},     32'd0);
      chk("t1_op_ready", {31'd0, op_ready}, 32'd0);
      check_outs();
      @(negedge clk);
      rst = 1'b0;
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
